// File: rtl/nibble_serial_comparator_ctrl.sv
// Nibble-serial unsigned magnitude comparator.
// One look-ahead cell is reused each cycle, walking from the most significant
// nibble down. The compare stops at the first nibble that differs.

// Marks the most significant differing bit of two nibbles (one-hot, or zero if equal).
module look_ahead_logic_cell (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] c
);

  logic [3:0] diff;

  assign diff = a ^ b;

  assign c[3] = diff[3];
  assign c[2] = diff[2] & ~diff[3];
  assign c[1] = diff[1] & ~(|diff[3:2]);
  assign c[0] = diff[0] & ~(|diff[3:1]);

endmodule

module nibble_serial_comparator_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic                          i_CLK,
  input  logic                          i_RST,
  input  logic                          i_START,
  output logic                          o_READY,
  input  logic [WIDTH-1:0]              i_OPERAND_A,
  input  logic [WIDTH-1:0]              i_OPERAND_B,
  input  logic                          i_ABORT,
  output logic                          o_BUSY,
  output logic                          o_DONE,
  output logic                          o_A_GT_B,
  output logic                          o_A_LT_B,
  output logic                          o_A_EQ_B,
  output logic [$clog2(WIDTH/4):0]      o_CYCLES
);

  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N) + 1;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("nibble_serial_comparator_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [IW-1:0]     index;
  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [3:0]        cell_out;
  logic              a_bit_at_diff;

  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              gt_q;
  logic              lt_q;
  logic              eq_q;
  logic [CW-1:0]     cycles_q;

  // Select the nibble pair currently under examination from the latched operands.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (index == IW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  look_ahead_logic_cell u_cell (
    .a (a_nib),
    .b (b_nib),
    .c (cell_out)
  );

  // A's bit at the first differing position decides which operand is larger.
  assign a_bit_at_diff = |(a_nib & cell_out);

  // Sequencer: accept, scan nibbles MSB first, pulse done, return to idle.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state    <= ST_IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      index    <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      gt_q     <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      cycles_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (i_START) begin
            a_reg    <= i_OPERAND_A;
            b_reg    <= i_OPERAND_B;
            index    <= IW'(N - 1);
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
            cycles_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state    <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (i_ABORT) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= ST_IDLE;
          end else if (cell_out != 4'b0000) begin
            gt_q     <= a_bit_at_diff;
            lt_q     <= ~a_bit_at_diff;
            eq_q     <= 1'b0;
            cycles_q <= CW'(N) - CW'(index);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end else if (index == '0) begin
            eq_q     <= 1'b1;
            cycles_q <= CW'(N);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= ST_DONE;
          end else begin
            index <= index - IW'(1);
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_READY  = ready_q;
  assign o_BUSY   = busy_q;
  assign o_DONE   = done_q;
  assign o_A_GT_B = gt_q;
  assign o_A_LT_B = lt_q;
  assign o_A_EQ_B = eq_q;
  assign o_CYCLES = cycles_q;

endmodule

// File: tb/tb_nibble_serial_comparator_ctrl.sv
// Directed bench for the nibble-serial comparator with a result scoreboard.
// Expected results and completion cycles are queued when a compare is started
// and checked by a monitor whenever the design pulses o_DONE.

module tb_nibble_serial_comparator_ctrl;

  localparam int W  = 16;
  localparam int N  = W / 4;
  localparam int CW = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          ready;
  logic          busy;
  logic          done;
  logic          gt;
  logic          lt;
  logic          eq;
  logic [CW-1:0] cycles;

  typedef struct packed {
    logic          gt;
    logic          lt;
    logic          eq;
    logic [CW-1:0] cyc;
    int            done_at;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   cycle_cnt = 0;
  bit   prev_done = 1'b0;

  nibble_serial_comparator_ctrl #(.WIDTH(W)) dut (
    .i_CLK       (clk),
    .i_RST       (rst),
    .i_START     (start),
    .o_READY     (ready),
    .i_OPERAND_A (op_a),
    .i_OPERAND_B (op_b),
    .i_ABORT     (abort),
    .o_BUSY      (busy),
    .o_DONE      (done),
    .o_A_GT_B    (gt),
    .o_A_LT_B    (lt),
    .o_A_EQ_B    (eq),
    .o_CYCLES    (cycles)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to timestamp accept and completion edges.
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkFlags(input logic g, input logic l, input logic e, input logic [CW-1:0] c);
    checkOutput("flag_gt", 32'(gt), 32'(g));
    checkOutput("flag_lt", 32'(lt), 32'(l));
    checkOutput("flag_eq", 32'(eq), 32'(e));
    checkOutput("cycles",  32'(cycles), 32'(c));
  endtask

  // Reference: unsigned compare, nibbles examined counted MSB first.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int acc);
    exp_t e;
    e.gt  = (x > y);
    e.lt  = (x < y);
    e.eq  = (x == y);
    e.cyc = CW'(N);
    for (int i = N - 1; i >= 0; i--) begin
      if (x[4*i +: 4] != y[4*i +: 4]) begin
        e.cyc = CW'(N - i);
        break;
      end
    end
    e.done_at = acc + int'(e.cyc);
    return e;
  endfunction

  // Monitor: score every done pulse and confirm it lasts a single cycle.
  always @(negedge clk) begin
    if (prev_done) begin
      checkOutput("done_one_cycle", 32'(done), 32'd0);
      checkOutput("ready_after_done", 32'(ready), 32'd1);
    end
    prev_done = (done === 1'b1);
    if (done === 1'b1) begin
      checkOutput("done_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        checkFlags(e.gt, e.lt, e.eq, e.cyc);
        checkOutput("done_latency", 32'(cycle_cnt), 32'(e.done_at));
      end
    end
  end

  // Wait for ready, present one request for a single edge, then scramble operands.
  task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic with_abort, input bit expect_done);
    int n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1;
    abort = with_abort;
    op_a  = x;
    op_b  = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    if (expect_done) sb.push_back(model(x, y, cycle_cnt));
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    checkOutput("ready_after_accept", 32'(ready), 32'd0);
    op_a = W'($urandom);
    op_b = W'($urandom);
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((sb.size() != 0 || ready !== 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
    checkOutput("drain_ready", 32'(ready), 32'd1);
  endtask

  // Hard stop in case something above fails to return.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(ready), 32'd1);
    checkOutput("reset_busy",  32'(busy),  32'd0);
    checkOutput("reset_done",  32'(done),  32'd0);
    checkFlags(1'b0, 1'b0, 1'b0, '0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] MSB nibble decides on first step");
    applyStimulus(16'h8000, 16'h7FFF, 1'b0, 1'b1);
    waitDrain();
    checkFlags(1'b1, 1'b0, 1'b0, CW'(1));

    $display("[TB] difference in least significant nibble");
    applyStimulus(16'h1234, 16'h1235, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] equal operands and held result");
    applyStimulus(16'hBEEF, 16'hBEEF, 1'b0, 1'b1);
    waitDrain();
    repeat (10) @(negedge clk);
    checkFlags(1'b0, 1'b0, 1'b1, CW'(4));
    applyStimulus(16'h0F00, 16'h0E00, 1'b0, 1'b1);
    waitDrain();
    checkFlags(1'b1, 1'b0, 1'b0, CW'(2));

    $display("[TB] start during scan is ignored");
    applyStimulus(16'h0001, 16'h0000, 1'b0, 1'b1);
    start = 1'b1;
    op_a  = 16'hFFFF;
    op_b  = 16'h0000;
    @(negedge clk);
    checkOutput("ready_in_scan", 32'(ready), 32'd0);
    @(negedge clk);
    start = 1'b0;
    waitDrain();
    checkFlags(1'b1, 1'b0, 1'b0, CW'(4));

    $display("[TB] reset in the middle of a scan");
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_mid_ready", 32'(ready), 32'd1);
    checkOutput("rst_mid_busy",  32'(busy),  32'd0);
    repeat (8) @(negedge clk);
    checkFlags(1'b0, 1'b0, 1'b0, '0);

    $display("[TB] abort in the middle of a scan");
    applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort_ready", 32'(ready), 32'd1);
    checkOutput("abort_busy",  32'(busy),  32'd0);
    repeat (8) @(negedge clk);
    checkFlags(1'b0, 1'b0, 1'b0, '0);

    $display("[TB] start together with abort while idle");
    applyStimulus(16'h0010, 16'h0100, 1'b1, 1'b1);
    waitDrain();
    checkFlags(1'b0, 1'b1, 1'b0, CW'(2));

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_comparator_ctrl.md
Name: nibble_serial_comparator_ctrl

Overview:
Sequencer that performs a WIDTH-bit unsigned magnitude compare by time-sharing one look_ahead_logic_cell instance, one 4-bit nibble per cycle, MSB nibble first. It terminates early at the first differing nibble. It sits between a requester (valid/ready start handshake) and the compare result consumers, and reports GT/LT/EQ plus the number of nibbles examined.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of 4 and at least 4 (elaboration error otherwise)
N (localparam), WIDTH/4, number of nibbles
CW (localparam), $clog2(N)+1, width of o_CYCLES

Ports:
i_CLK  input  1  clock, all state updates on rising edge
i_RST  input  1  synchronous, active-high reset
i_START  input  1  request valid; accepted when i_START && o_READY
o_READY  output  1  high only in IDLE
i_OPERAND_A  input  WIDTH  operand A, sampled only at accept edge
i_OPERAND_B  input  WIDTH  operand B, sampled only at accept edge
i_ABORT  input  1  synchronous abort of an in-progress compare
o_BUSY  output  1  high in SCAN
o_DONE  output  1  one-cycle completion pulse
o_A_GT_B  output  1  A > B (unsigned)
o_A_LT_B  output  1  A < B
o_A_EQ_B  output  1  A == B
o_CYCLES  output  CW  nibbles examined for last completed compare (1..N)

Behaviour:
- Reset (i_RST high at an edge): state=IDLE; o_READY=1; o_BUSY=0; o_DONE=0; o_A_GT_B, o_A_LT_B, o_A_EQ_B=0; o_CYCLES=0; operand registers and index cleared. Reset overrides start and abort, including mid-SCAN.
- FSM states: IDLE, SCAN, DONE.
- IDLE: on accept, latch A and B, set index=N-1, clear all result flags and o_CYCLES, go to SCAN. i_ABORT is ignored in IDLE; start plus abort in the same cycle is an accepted start.
- SCAN: drive the cell with A[4*index+:4] and B[4*index+:4]. Cell output c[3:0] is one-hot at the most-significant differing bit k, or zero.
  - c != 0: set GT = latched A bit k; LT = ~GT; EQ=0; o_CYCLES=N-index; go to DONE.
  - c == 0 and index==0: EQ=1; o_CYCLES=N; go to DONE.
  - Otherwise: index decrements, stay in SCAN.
- i_ABORT high in SCAN: go to IDLE at the next edge. No o_DONE; flags and o_CYCLES stay 0. Abort takes priority over a decision in the same cycle.
- DONE: o_DONE=1 for exactly this one cycle, then IDLE unconditionally. i_START is not accepted in DONE (o_READY=0).
- Latency: k nibbles examined gives the decision registered at the k-th edge after the accept edge. o_DONE is high in the following cycle. o_READY is high again one cycle later. Min latency 1, max N; one op per k+2 cycles.
- Result flags are registered and held stable from DONE until the next accept or reset. After a completed compare exactly one of GT/LT/EQ is high; all are zero otherwise.
- Operand inputs may change freely after accept without affecting the result. i_START while not ready is ignored, with no queuing.
- o_BUSY = (state==SCAN); o_READY = (state==IDLE).

Test Plan:
1. WIDTH=16, A=0x8000, B=0x7FFF, start -> o_DONE one cycle after the first edge following accept; GT=1, LT=0, EQ=0, o_CYCLES=1.
2. A=0x1234, B=0x1235 -> LT=1, o_CYCLES=4, o_DONE exactly 4 cycles after the accept edge, high for 1 cycle; o_READY returns the next cycle.
3. A=B=0xBEEF -> EQ=1, GT=LT=0, o_CYCLES=4; flags held through 10 idle cycles; then A=0x0F00, B=0x0E00 -> GT=1, o_CYCLES=2.
4. Accept A=0x0001, B=0x0000; during SCAN assert i_START with A=0xFFFF, B=0x0000 and change input operands -> ignored; result GT, o_CYCLES=4.
5. Accept A=0x0001, B=0x0002; i_RST high at the 2nd SCAN edge -> IDLE, o_READY=1, all flags 0, no o_DONE ever. Abort variant: i_ABORT in the 2nd SCAN cycle -> same result with no reset applied.
6. In IDLE, i_ABORT and i_START together with A=0x0010, B=0x0100 -> start accepted; LT=1, o_CYCLES=2.
